// File: rtl/risc_pkg.sv
// risc_pkg: opcodes, control states and flag bit positions for the RISC accumulator machine.
package risc_pkg;
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_NOTA = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_JZ   = 4'h9;
    localparam logic [3:0] OP_JC   = 4'hA;
    localparam logic [3:0] OP_HLT  = 4'hF;

    localparam int FLAG_CF = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_SF = 1;
    localparam int FLAG_ZF = 0;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALT
    } state_t;
endpackage

// File: rtl/risc_decode.sv
// risc_decode: classifies an opcode and resolves conditional jumps against the registered flags.
module risc_decode
    import risc_pkg::*;
(
    input  logic [3:0] op,
    input  logic [3:0] flags,
    output logic       is_alu,
    output logic       is_ldi,
    output logic       take_jump,
    output logic       is_halt
);
    logic unused_flags;

    assign is_alu       = op inside {[OP_ADD:OP_NOTA]};
    assign is_ldi       = op == OP_LDI;
    assign is_halt      = op == OP_HLT;
    assign take_jump    = (op == OP_JMP) || (op == OP_JZ && flags[FLAG_ZF]) || (op == OP_JC && flags[FLAG_CF]);
    assign unused_flags = ^{flags[FLAG_OF], flags[FLAG_SF]};
endmodule

// File: rtl/risc_control_unit.sv
// risc_control_unit: multi-cycle fetch/decode/execute/writeback sequencer driving an external ALU.
module risc_control_unit
    import risc_pkg::*;
#(
    parameter int Width   = 8,
    parameter int PcWidth = 5
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               RUN,
    output logic [PcWidth-1:0] PC,
    output logic               IMEM_REQ,
    input  logic               IMEM_ACK,
    input  logic [Width+3:0]   IMEM_DATA,
    output logic [3:0]         ALU_OPCODE,
    output logic [Width-1:0]   ALU_A,
    output logic [Width-1:0]   ALU_B,
    output logic               ALU_EN,
    output logic               ALU_OE,
    input  logic [Width-1:0]   ALU_OUT,
    input  logic               ALU_CF,
    input  logic               ALU_OF,
    input  logic               ALU_SF,
    input  logic               ALU_ZF,
    output logic [Width-1:0]   ACC,
    output logic [3:0]         FLAGS,
    output logic               HALTED
);
    state_t             state, state_nxt;
    logic [Width+3:0]   ir;
    logic [3:0]         op;
    logic [Width-1:0]   imm;
    logic               is_alu, is_ldi, take_jump, is_halt;

    assign op    = ir[Width+3:Width];
    assign imm   = ir[Width-1:0];
    assign ALU_A = ACC;
    assign ALU_B = imm;

    risc_decode u_decode (
        .op        (op),
        .flags     (FLAGS),
        .is_alu    (is_alu),
        .is_ldi    (is_ldi),
        .take_jump (take_jump),
        .is_halt   (is_halt)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_FETCH;
            PC    <= '0;
            ir    <= '0;
            ACC   <= '0;
            FLAGS <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_FETCH && RUN && IMEM_ACK)
                ir <= IMEM_DATA;
            if (state == S_DECODE && !is_halt)
                PC <= take_jump ? imm[PcWidth-1:0] : PC + PcWidth'(1);
            if (state == S_DECODE && is_ldi)
                ACC <= imm;
            if (state == S_WRITEBACK) begin
                ACC   <= ALU_OUT;
                FLAGS <= {ALU_CF, ALU_OF, ALU_SF, ALU_ZF};
            end
        end
    end

    // OPCODE stays on the ALU through WRITEBACK because its flag outputs depend on it.
    always_comb begin
        state_nxt  = state;
        IMEM_REQ   = 1'b0;
        ALU_EN     = 1'b0;
        ALU_OE     = 1'b0;
        ALU_OPCODE = OP_NOP;
        HALTED     = 1'b0;
        case (state)
            S_FETCH: begin
                IMEM_REQ  = RUN;
                state_nxt = (RUN && IMEM_ACK) ? S_DECODE : S_FETCH;
            end
            S_DECODE:    state_nxt = is_halt ? S_HALT : is_alu ? S_EXECUTE : S_FETCH;
            S_EXECUTE: begin
                ALU_EN     = 1'b1;
                ALU_OPCODE = op;
                state_nxt  = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                ALU_OE     = 1'b1;
                ALU_OPCODE = op;
                state_nxt  = S_FETCH;
            end
            S_HALT:      HALTED = 1'b1;
            default:     state_nxt = S_FETCH;
        endcase
    end
endmodule

// File: tb/tb_risc_control_unit.sv
// tb_risc_control_unit: directed checks of the sequencer against a behavioural 8-bit ALU.
module tb_risc_control_unit;
    import risc_pkg::*;

    logic        CLK = 1'b0;
    logic        RST, RUN, IMEM_ACK;
    logic [11:0] IMEM_DATA;
    logic [4:0]  PC;
    logic        IMEM_REQ, ALU_EN, ALU_OE, HALTED;
    logic [3:0]  ALU_OPCODE, FLAGS;
    logic [7:0]  ALU_A, ALU_B, ALU_OUT, ACC;
    logic        ALU_CF, ALU_OF, ALU_SF, ALU_ZF;
    logic [7:0]  alu_res = '0;
    logic        alu_cf = 1'b0, alu_of = 1'b0;
    logic [3:0]  pins;
    int          checks = 0, errors = 0;

    always #5 CLK = ~CLK;

    risc_control_unit dut (
        .CLK(CLK), .RST(RST), .RUN(RUN), .PC(PC), .IMEM_REQ(IMEM_REQ), .IMEM_ACK(IMEM_ACK),
        .IMEM_DATA(IMEM_DATA), .ALU_OPCODE(ALU_OPCODE), .ALU_A(ALU_A), .ALU_B(ALU_B),
        .ALU_EN(ALU_EN), .ALU_OE(ALU_OE), .ALU_OUT(ALU_OUT), .ALU_CF(ALU_CF), .ALU_OF(ALU_OF),
        .ALU_SF(ALU_SF), .ALU_ZF(ALU_ZF), .ACC(ACC), .FLAGS(FLAGS), .HALTED(HALTED)
    );

    // Reference ALU: result and carry/overflow registered on the EN edge.
    function automatic logic [9:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = '0;
        case (op)
            OP_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                return {s[8], (a[7] == b[7]) && (s[7] != a[7]), s[7:0]};
            end
            OP_SUB: begin
                s = {1'b0, a} - {1'b0, b};
                return {s[8], (a[7] != b[7]) && (s[7] != a[7]), s[7:0]};
            end
            OP_AND:  return {2'b00, a & b};
            OP_OR:   return {2'b00, a | b};
            OP_XOR:  return {2'b00, a ^ b};
            OP_NOTA: return {2'b00, ~a};
            default: return {2'b00, s[7:0]};
        endcase
    endfunction

    always @(posedge CLK)
        if (ALU_EN) {alu_cf, alu_of, alu_res} <= alu_fn(ALU_OPCODE, ALU_A, ALU_B);

    assign ALU_OUT = alu_res;
    assign ALU_CF  = alu_cf;
    assign ALU_OF  = alu_of;
    assign ALU_SF  = alu_res[7];
    assign ALU_ZF  = alu_res == 8'h00;

    task automatic cyc();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic run_instr(input logic [11:0] instr, input int n);
        IMEM_ACK  = 1'b1;
        IMEM_DATA = instr;
        cyc();
        IMEM_ACK = 1'b0;
        repeat (n - 1) cyc();
    endtask

    task automatic test_reset();
        checks++; if (PC !== 5'h00) begin errors++; $display("FAIL reset_pc got %h exp 00", PC); end
        checks++; if (ACC !== 8'h00) begin errors++; $display("FAIL reset_acc got %h exp 00", ACC); end
        checks++; if (FLAGS !== 4'h0) begin errors++; $display("FAIL reset_flags got %h exp 0", FLAGS); end
        checks++; if ({IMEM_REQ, ALU_EN, ALU_OE, HALTED} !== 4'b0000) begin errors++; $display("FAIL reset_ctl got %b exp 0000", {IMEM_REQ, ALU_EN, ALU_OE, HALTED}); end
        checks++; if (ALU_OPCODE !== 4'h0) begin errors++; $display("FAIL reset_opcode got %h exp 0", ALU_OPCODE); end
        RST = 1'b0;
        cyc();
        checks++; if (IMEM_REQ !== 1'b0 || PC !== 5'h00) begin errors++; $display("FAIL idle_norun got req=%b pc=%h exp req=0 pc=00", IMEM_REQ, PC); end
    endtask

    task automatic test_ldi();
        RUN = 1'b1; IMEM_ACK = 1'b1; IMEM_DATA = {OP_LDI, 8'h7F};
        #1;
        checks++; if (IMEM_REQ !== 1'b1) begin errors++; $display("FAIL ldi_req got %b exp 1", IMEM_REQ); end
        @(negedge CLK);
        IMEM_ACK = 1'b0;
        checks++; if (PC !== 5'h00 || IMEM_REQ !== 1'b0) begin errors++; $display("FAIL ldi_decode got pc=%h req=%b exp pc=00 req=0", PC, IMEM_REQ); end
        cyc();
        checks++; if (ACC !== 8'h7F) begin errors++; $display("FAIL ldi_acc got %h exp 7f", ACC); end
        checks++; if (PC !== 5'h01) begin errors++; $display("FAIL ldi_pc got %h exp 01", PC); end
        checks++; if (FLAGS !== 4'h0) begin errors++; $display("FAIL ldi_flags got %h exp 0", FLAGS); end
        checks++; if (IMEM_REQ !== 1'b1) begin errors++; $display("FAIL ldi_refetch got %b exp 1", IMEM_REQ); end
    endtask

    task automatic test_add();
        IMEM_ACK = 1'b1; IMEM_DATA = {OP_ADD, 8'h01};
        cyc();
        IMEM_ACK = 1'b0;
        checks++; if (ALU_EN !== 1'b0 || ALU_OE !== 1'b0) begin errors++; $display("FAIL add_dec_en got en=%b oe=%b exp 0 0", ALU_EN, ALU_OE); end
        cyc();
        checks++; if (ALU_EN !== 1'b1 || ALU_OE !== 1'b0) begin errors++; $display("FAIL add_ex_en got en=%b oe=%b exp 1 0", ALU_EN, ALU_OE); end
        checks++; if (ALU_OPCODE !== OP_ADD) begin errors++; $display("FAIL add_ex_op got %h exp 2", ALU_OPCODE); end
        checks++; if (ALU_A !== 8'h7F || ALU_B !== 8'h01) begin errors++; $display("FAIL add_operands got a=%h b=%h exp 7f 01", ALU_A, ALU_B); end
        cyc();
        pins = {ALU_CF, ALU_OF, ALU_SF, ALU_ZF};
        checks++; if (ALU_EN !== 1'b0 || ALU_OE !== 1'b1) begin errors++; $display("FAIL add_wb_en got en=%b oe=%b exp 0 1", ALU_EN, ALU_OE); end
        checks++; if (ALU_OPCODE !== OP_ADD) begin errors++; $display("FAIL add_wb_op got %h exp 2", ALU_OPCODE); end
        checks++; if (ACC !== 8'h7F) begin errors++; $display("FAIL add_wb_acc got %h exp 7f", ACC); end
        cyc();
        checks++; if (ACC !== 8'h80) begin errors++; $display("FAIL add_acc got %h exp 80", ACC); end
        checks++; if (FLAGS !== 4'b0110 || FLAGS !== pins) begin errors++; $display("FAIL add_flags got %b exp 0110 (pins %b)", FLAGS, pins); end
        checks++; if (ALU_OE !== 1'b0 || ALU_OPCODE !== 4'h0 || PC !== 5'h02) begin errors++; $display("FAIL add_done got oe=%b op=%h pc=%h exp 0 0 02", ALU_OE, ALU_OPCODE, PC); end
    endtask

    task automatic test_jumps();
        run_instr({OP_SUB, 8'h80}, 4);
        checks++; if (ACC !== 8'h00 || FLAGS !== 4'b0001) begin errors++; $display("FAIL sub_zero got acc=%h flags=%b exp 00 0001", ACC, FLAGS); end
        run_instr({OP_JZ, 8'h10}, 2);
        checks++; if (PC !== 5'h10) begin errors++; $display("FAIL jz_taken got %h exp 10", PC); end
        run_instr({OP_ADD, 8'h01}, 4);
        run_instr({OP_JZ, 8'h05}, 2);
        checks++; if (PC !== 5'h12) begin errors++; $display("FAIL jz_not_taken got %h exp 12", PC); end
        run_instr({OP_SUB, 8'h02}, 4);
        checks++; if (ACC !== 8'hFF || FLAGS !== 4'b1010) begin errors++; $display("FAIL sub_borrow got acc=%h flags=%b exp ff 1010", ACC, FLAGS); end
        run_instr({OP_JC, 8'h03}, 2);
        checks++; if (PC !== 5'h03) begin errors++; $display("FAIL jc_taken got %h exp 03", PC); end
        run_instr({OP_AND, 8'h00}, 4);
        run_instr({OP_JC, 8'h1F}, 2);
        checks++; if (PC !== 5'h05) begin errors++; $display("FAIL jc_not_taken got %h exp 05", PC); end
        run_instr({OP_JMP, 8'h1F}, 2);
        checks++; if (PC !== 5'h1F) begin errors++; $display("FAIL jmp got %h exp 1f", PC); end
    endtask

    task automatic test_wrap_delay();
        run_instr({OP_NOP, 8'h00}, 2);
        checks++; if (PC !== 5'h00) begin errors++; $display("FAIL pc_wrap got %h exp 00", PC); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (IMEM_REQ !== 1'b1 || PC !== 5'h00) begin errors++; $display("FAIL ack_wait%0d got req=%b pc=%h exp 1 00", i, IMEM_REQ, PC); end
            cyc();
        end
        run_instr({4'hC, 8'hAA}, 2);
        checks++; if (PC !== 5'h01 || ACC !== 8'h00) begin errors++; $display("FAIL reserved_nop got pc=%h acc=%h exp 01 00", PC, ACC); end
    endtask

    task automatic test_rst_wb();
        run_instr({OP_LDI, 8'h55}, 2);
        IMEM_ACK = 1'b1; IMEM_DATA = {OP_ADD, 8'h01};
        cyc();
        IMEM_ACK = 1'b0;
        cyc();
        cyc();
        checks++; if (ALU_OE !== 1'b1 || ACC !== 8'h55) begin errors++; $display("FAIL rst_pre_wb got oe=%b acc=%h exp 1 55", ALU_OE, ACC); end
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        checks++; if (ACC !== 8'h00 || FLAGS !== 4'h0 || PC !== 5'h00) begin errors++; $display("FAIL rst_wb got acc=%h flags=%h pc=%h exp 00 0 00", ACC, FLAGS, PC); end
        checks++; if (IMEM_REQ !== 1'b1 || ALU_OE !== 1'b0) begin errors++; $display("FAIL rst_wb_fetch got req=%b oe=%b exp 1 0", IMEM_REQ, ALU_OE); end
    endtask

    task automatic test_halt();
        run_instr({OP_HLT, 8'h00}, 2);
        checks++; if (HALTED !== 1'b1 || IMEM_REQ !== 1'b0 || PC !== 5'h00) begin errors++; $display("FAIL halt got halted=%b req=%b pc=%h exp 1 0 00", HALTED, IMEM_REQ, PC); end
        IMEM_ACK = 1'b1; IMEM_DATA = {OP_LDI, 8'h33};
        cyc();
        cyc();
        IMEM_ACK = 1'b0;
        checks++; if (HALTED !== 1'b1 || ACC !== 8'h00 || PC !== 5'h00 || ALU_EN !== 1'b0) begin errors++; $display("FAIL halt_ack got halted=%b acc=%h pc=%h en=%b exp 1 00 00 0", HALTED, ACC, PC, ALU_EN); end
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        checks++; if (HALTED !== 1'b0 || IMEM_REQ !== 1'b1) begin errors++; $display("FAIL halt_rst got halted=%b req=%b exp 0 1", HALTED, IMEM_REQ); end
    endtask

    task automatic test_run_drop();
        run_instr({OP_LDI, 8'h10}, 2);
        IMEM_ACK = 1'b1; IMEM_DATA = {OP_XOR, 8'h90};
        cyc();
        IMEM_ACK = 1'b0;
        cyc();
        RUN = 1'b0;
        checks++; if (ALU_EN !== 1'b1) begin errors++; $display("FAIL drop_ex got %b exp 1", ALU_EN); end
        cyc();
        checks++; if (ALU_OE !== 1'b1) begin errors++; $display("FAIL drop_wb got %b exp 1", ALU_OE); end
        cyc();
        checks++; if (ACC !== 8'h80 || FLAGS !== 4'b0010 || PC !== 5'h02) begin errors++; $display("FAIL drop_result got acc=%h flags=%b pc=%h exp 80 0010 02", ACC, FLAGS, PC); end
        checks++; if (IMEM_REQ !== 1'b0) begin errors++; $display("FAIL drop_req got %b exp 0", IMEM_REQ); end
        IMEM_ACK = 1'b1; IMEM_DATA = {OP_LDI, 8'h33};
        cyc();
        cyc();
        IMEM_ACK = 1'b0;
        checks++; if (PC !== 5'h02 || ACC !== 8'h80 || IMEM_REQ !== 1'b0) begin errors++; $display("FAIL drop_idle got pc=%h acc=%h req=%b exp 02 80 0", PC, ACC, IMEM_REQ); end
    endtask

    initial begin
        RST = 1'b1; RUN = 1'b0; IMEM_ACK = 1'b0; IMEM_DATA = '0;
        repeat (2) @(negedge CLK);
        test_reset();
        test_ldi();
        test_add();
        test_jumps();
        test_wrap_delay();
        test_rst_wb();
        test_halt();
        test_run_drop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
